mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 65 ++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, DMA) single-port memory arbiter with starvation guard.
// Defining ARB_ROUND_ROBIN_EN resolves fresh ties round-robin; otherwise the CPU wins ties.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RUN    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [3:0]            cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic [3:0]            dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    localparam int CW = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(MAX_RUN);
    logic          pend, owner, last_win, both, pick_dma, tie_dma;
    logic [CW-1:0] run_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    assign tie_dma = ~last_win;
`else
    assign tie_dma = 1'b0;
`endif
    assign both = cpu_req & dma_req;
    // Under contention: fresh tie uses policy, an exhausted run hands over, otherwise the run continues.
    assign pick_dma = (run_cnt == '0) ? tie_dma : (run_cnt >= RUN_MAX) ? ~last_win : last_win;
    assign cpu_gnt = ~rst & cpu_req & (~dma_req | ~pick_dma);
    assign dma_gnt = ~rst & dma_req & (~cpu_req | pick_dma);
    assign mem_en   = cpu_gnt | dma_gnt;
    assign mem_we   = cpu_gnt ? cpu_we    : dma_gnt ? dma_we    : 4'h0;
    assign mem_addr = cpu_gnt ? cpu_addr  : dma_gnt ? dma_addr  : '0;
    assign mem_din  = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
    assign cpu_rvalid = ~rst & pend & ~owner;
    assign dma_rvalid = ~rst & pend & owner;
    assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
    assign dma_rdata  = dma_rvalid ? mem_dout : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            owner    <= 1'b0;
            last_win <= 1'b1;
            run_cnt  <= '0;
        end else begin
            pend  <= mem_en & (mem_we == 4'h0);
            owner <= dma_gnt;
            if (mem_en) last_win <= dma_gnt;
            run_cnt <= !both ? '0 : (run_cnt == '0 || dma_gnt != last_win) ? CW'(1) : run_cnt + CW'(1);
        end
    end
endmodule
